// File: rtl/mips_pkg.sv
// Shared constants and FSM encoding for the MIPS fetch front end.
package mips_pkg;
    localparam int          XLEN             = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        SEQ   = 1'b0,
        JWAIT = 1'b1
    } pc_state_e;
endpackage

// File: rtl/pc_register.sv
// Program counter storage: enabled load, asynchronous active-low reset to RESET_VAL.
module pc_register
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VAL = DEFAULT_RESET_PC
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_d,
    output logic [XLEN-1:0] o_q
);
    logic [XLEN-1:0] r_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)      r_q <= RESET_VAL;
        else if (i_load) r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/pc_next_unit.sv
// Next-PC selection: JR/JALR, branches, and two-cycle J/JAL (target arrives a cycle late).
module pc_next_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        En,
    input  logic        Jump,
    input  logic [27:0] JumpAddr28,
    input  logic        Branch,
    input  logic [31:0] BranchOff,
    input  logic        JumpReg,
    input  logic [31:0] RegAddr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        Redirect,
    output logic        Busy,
    output logic        AddrErr
);
    pc_state_e   r_state, w_state_nxt;
    logic [3:0]  r_upper;
    logic        r_redirect, r_addr_err;
    logic        w_load, w_capture, w_redirect, w_addr_err;
    logic [31:0] w_pc_nxt;

    pc_register #(.RESET_VAL(RESET_PC)) u_pc (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .i_load (w_load),
        .i_d    (w_pc_nxt),
        .o_q    (PC)
    );

    assign PCPlus4 = PC + PC_STEP;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pc_nxt    = PC;
        w_capture   = 1'b0;
        w_redirect  = 1'b0;
        w_addr_err  = 1'b0;
        case (r_state)
            SEQ: begin
                if (En) begin
                    if (JumpReg) begin
                        w_load     = 1'b1;
                        w_pc_nxt   = {RegAddr[31:2], 2'b00};
                        w_redirect = 1'b1;
                        w_addr_err = |RegAddr[1:0];
                    end else if (Branch) begin
                        w_load     = 1'b1;
                        w_pc_nxt   = PCPlus4 + BranchOff;
                        w_redirect = 1'b1;
                    end else if (Jump) begin
                        // PC holds; region bits are taken from the delay-slot address now.
                        w_capture   = 1'b1;
                        w_state_nxt = JWAIT;
                    end else begin
                        w_load   = 1'b1;
                        w_pc_nxt = PCPlus4;
                    end
                end
            end
            JWAIT: begin
                w_load      = 1'b1;
                w_pc_nxt    = {r_upper, JumpAddr28};
                w_redirect  = 1'b1;
                w_state_nxt = SEQ;
            end
            default: w_state_nxt = SEQ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= SEQ;
            r_upper    <= 4'h0;
            r_redirect <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_redirect <= w_redirect;
            r_addr_err <= w_addr_err;
            if (w_capture) r_upper <= PCPlus4[31:28];
        end
    end

    assign Redirect = r_redirect;
    assign AddrErr  = r_addr_err;
    assign Busy     = (r_state == JWAIT);
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed vector bench for pc_next_unit: sequential table plus reset corner sequences.
module tb_pc_next_unit;
    logic        Clk, Rst_n, En, Jump, Branch, JumpReg;
    logic [27:0] JumpAddr28;
    logic [31:0] BranchOff, RegAddr, PC, PCPlus4;
    logic        Redirect, Busy, AddrErr;

    int n_cmp = 0;
    int n_bad = 0;

    pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .En(En), .Jump(Jump), .JumpAddr28(JumpAddr28),
        .Branch(Branch), .BranchOff(BranchOff), .JumpReg(JumpReg), .RegAddr(RegAddr),
        .PC(PC), .PCPlus4(PCPlus4), .Redirect(Redirect), .Busy(Busy), .AddrErr(AddrErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        en, jump, br, jr;
        logic [27:0] ja28;
        logic [31:0] boff, ra;
        logic [31:0] pc;
        logic        redir, busy, aerr;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic en, input logic jump, input logic [27:0] ja28,
                                input logic br, input logic [31:0] boff,
                                input logic jr, input logic [31:0] ra,
                                input logic [31:0] pc, input logic redir,
                                input logic busy, input logic aerr);
        vec_t v;
        v.en = en; v.jump = jump; v.ja28 = ja28; v.br = br; v.boff = boff;
        v.jr = jr; v.ra = ra; v.pc = pc; v.redir = redir; v.busy = busy; v.aerr = aerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic redir,
                           input logic busy, input logic aerr);
        chk({tag, ".PC"}, PC, pc);
        chk({tag, ".PCPlus4"}, PCPlus4, pc + 32'd4);
        chk({tag, ".Redirect"}, {31'd0, Redirect}, {31'd0, redir});
        chk({tag, ".Busy"}, {31'd0, Busy}, {31'd0, busy});
        chk({tag, ".AddrErr"}, {31'd0, AddrErr}, {31'd0, aerr});
    endtask

    task automatic drive_idle(input logic en);
        En = en; Jump = 0; Branch = 0; JumpReg = 0;
        JumpAddr28 = '0; BranchOff = '0; RegAddr = '0;
    endtask

    initial begin
        //          en jmp ja28        br boff          jr ra             pc             rd bz ae
        vecs[0]  = mk(1, 0, 28'h0,      0, 32'h0,        0, 32'h0,        32'h0000_0004, 0, 0, 0);
        vecs[1]  = mk(1, 0, 28'h0,      0, 32'h0,        0, 32'h0,        32'h0000_0008, 0, 0, 0);
        vecs[2]  = mk(1, 0, 28'h0,      0, 32'h0,        0, 32'h0,        32'h0000_000C, 0, 0, 0);
        vecs[3]  = mk(1, 0, 28'h0,      0, 32'h0,        1, 32'h1000_0010, 32'h1000_0010, 1, 0, 0);
        vecs[4]  = mk(1, 1, 28'h0,      0, 32'h0,        0, 32'h0,        32'h1000_0010, 0, 1, 0);
        vecs[5]  = mk(1, 0, 28'h000040C, 0, 32'h0,       0, 32'h0,        32'h1000_040C, 1, 0, 0);
        vecs[6]  = mk(1, 0, 28'h0,      0, 32'h0,        0, 32'h0,        32'h1000_0410, 0, 0, 0);
        vecs[7]  = mk(1, 0, 28'h0,      0, 32'h0,        1, 32'h0000_0100, 32'h0000_0100, 1, 0, 0);
        vecs[8]  = mk(1, 0, 28'h0,      1, 32'hFFFF_FFF0, 0, 32'h0,       32'h0000_00F4, 1, 0, 0);
        vecs[9]  = mk(1, 0, 28'h0,      0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0);
        vecs[10] = mk(1, 0, 28'h0,      0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0);
        vecs[11] = mk(1, 1, 28'h0,      1, 32'h40,       1, 32'h0040_0007, 32'h0040_0004, 1, 0, 1);
        vecs[12] = mk(1, 0, 28'h0,      0, 32'h0,        0, 32'h0,        32'h0040_0008, 0, 0, 0);
        vecs[13] = mk(0, 0, 28'h0,      1, 32'h40,       0, 32'h0,        32'h0040_0008, 0, 0, 0);
        vecs[14] = mk(0, 1, 28'h0,      0, 32'h0,        0, 32'h0,        32'h0040_0008, 0, 0, 0);
        vecs[15] = mk(1, 1, 28'h0,      0, 32'h0,        0, 32'h0,        32'h0040_0008, 0, 1, 0);
        vecs[16] = mk(0, 0, 28'h0000100, 0, 32'h0,       1, 32'h0000_8000, 32'h0000_0100, 1, 0, 0);
        vecs[17] = mk(0, 0, 28'h0,      0, 32'h0,        0, 32'h0,        32'h0000_0100, 0, 0, 0);
        vecs[18] = mk(1, 0, 28'h0,      1, 32'h20,       0, 32'h0,        32'h0000_0124, 1, 0, 0);

        Rst_n = 1'b0;
        drive_idle(1'b1);
        #1 chk_all("reset", 32'h0, 0, 0, 0);
        @(posedge Clk); #1 chk_all("reset_held", 32'h0, 0, 0, 0);
        @(negedge Clk);
        drive_idle(1'b0);
        Rst_n = 1'b1;
        @(posedge Clk); #1 chk_all("post_rst_en0", 32'h0, 0, 0, 0);
        @(negedge Clk);

        for (int i = 0; i < 19; i++) begin
            En = vecs[i].en; Jump = vecs[i].jump; JumpAddr28 = vecs[i].ja28;
            Branch = vecs[i].br; BranchOff = vecs[i].boff;
            JumpReg = vecs[i].jr; RegAddr = vecs[i].ra;
            @(posedge Clk);
            #1 chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].redir, vecs[i].busy, vecs[i].aerr);
            @(negedge Clk);
        end

        // Jump accepted, then reset during JWAIT: pending target must be abandoned.
        drive_idle(1'b1);
        Jump = 1'b1;
        @(posedge Clk); #1 chk_all("jwait_enter", 32'h0000_0124, 0, 1, 0);
        @(negedge Clk);
        drive_idle(1'b1);
        JumpAddr28 = 28'h0000ABC;
        Rst_n = 1'b0;
        #1 chk_all("rst_in_jwait", 32'h0, 0, 0, 0);
        @(posedge Clk); #1 chk_all("rst_in_jwait_edge", 32'h0, 0, 0, 0);
        @(negedge Clk);
        drive_idle(1'b0);
        Rst_n = 1'b1;
        @(posedge Clk); #1 chk_all("rst_release_en0", 32'h0, 0, 0, 0);
        @(negedge Clk);
        drive_idle(1'b1);
        @(posedge Clk); #1 chk_all("first_en_step", 32'h4, 0, 0, 0);
        @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC value loaded on reset.
REQ-002 The module SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-003 Port Clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port Rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port En: input, 1 bit, pipeline advance; 0 = stall.
REQ-006 Port Jump: input, 1 bit, J/JAL decoded in the current cycle.
REQ-007 Port JumpAddr28: input, 28 bits, the registered instr_index<<2; valid exactly one cycle after Jump.
REQ-008 Port Branch: input, 1 bit, conditional branch taken.
REQ-009 Port BranchOff: input, 32 bits, sign-extended immediate already shifted left by 2.
REQ-010 Port JumpReg: input, 1 bit, JR/JALR decoded.
REQ-011 Port RegAddr: input, 32 bits, register-file target address for JumpReg.
REQ-012 Port PC: output, 32 bits, current fetch address.
REQ-013 Port PCPlus4: output, 32 bits, equal to PC + 4.
REQ-014 Port Redirect: output, 1 bit, one-cycle pulse on each non-sequential PC load (fetch flush).
REQ-015 Port Busy: output, 1 bit, high while a jump target is pending.
REQ-016 Port AddrErr: output, 1 bit, one-cycle pulse when a misaligned RegAddr is used.

Function
REQ-017 The module SHALL have two FSM states: SEQ and JWAIT.
REQ-018 PCPlus4 SHALL be combinational, computed as PC + 32'd4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-019 In SEQ with En=0, PC SHALL hold, Jump/Branch/JumpReg SHALL be ignored, and Redirect and AddrErr SHALL be 0.
REQ-020 In SEQ with En=1, the priority order SHALL be JumpReg > Branch > Jump > sequential.
REQ-021 On JumpReg, the next PC SHALL be {RegAddr[31:2], 2'b00}, Redirect SHALL pulse, and AddrErr SHALL pulse if RegAddr[1:0] != 0.
REQ-022 On Branch, the next PC SHALL be PCPlus4 + BranchOff modulo 2^32, and Redirect SHALL pulse.
REQ-023 On Jump, the module SHALL capture PCPlus4[31:28] into an internal register, hold PC, and enter JWAIT; Busy SHALL be 1 from the next cycle.
REQ-024 In JWAIT, on the next rising edge the PC SHALL load {captured[3:0], JumpAddr28}, Redirect SHALL pulse, and the FSM SHALL return to SEQ, regardless of En and of other requests.
REQ-025 With no request and En=1, the next PC SHALL be PCPlus4.
REQ-026 Redirect and AddrErr SHALL be registered outputs, high for exactly the one cycle after the PC load they flag.
REQ-027 Busy SHALL be 1 if and only if the state is JWAIT.
REQ-028 Requests presented while in JWAIT SHALL be dropped; upstream holds them under Busy.

Reset
REQ-029 While Rst_n=0, the outputs SHALL be PC=RESET_PC, PCPlus4=RESET_PC+4, Redirect=0, Busy=0, AddrErr=0; the state SHALL be SEQ and the captured upper bits SHALL be 0.
REQ-030 Reset asserted in JWAIT SHALL abandon the pending jump, with no Redirect after release.
REQ-031 The first PC update after Rst_n deassertion SHALL occur on the first rising edge with En=1.

Structure
REQ-032 Package mips_pkg SHALL hold XLEN=32, the PC_STEP=4 constant, the default RESET_PC, and the FSM state enum (SEQ, JWAIT).
REQ-033 The design SHALL contain one sub-module, pc_register (32-bit register with async active-low reset, enable, and reset-value parameter); the next-PC mux and FSM SHALL stay in pc_next_unit.

Verification
REQ-034 Reset, then 3 cycles with En=1 and no requests -> PC = 0x0, then 0x4, 0x8, 0xC; Redirect=0 throughout.
REQ-035 PC=0x1000_0010; Jump=1 for one cycle; next cycle JumpAddr28=0x0000_40C -> Busy=1 for one cycle, then PC=0x1000_040C, and Redirect pulses once.
REQ-036 PC=0x0000_0100, Branch=1, BranchOff=0xFFFF_FFF0 -> next PC=0x0000_00F4; separately, with PC=0xFFFF_FFFC and no request -> next PC=0x0000_0000.
REQ-037 JumpReg=1, Branch=1, and Jump=1 all in one cycle with RegAddr=0x0040_0007 -> next PC=0x0040_0004, AddrErr=1 and Redirect=1 for one cycle, and no JWAIT entry.
REQ-038 Jump accepted, then Rst_n pulsed low during JWAIT -> PC=RESET_PC, Busy=0, and no Redirect after release; separately, En=0 with Branch=1 -> PC unchanged.
